// File: rtl/timer_ctrl_161.sv
// Sequencer for a cascaded 74x161 timer chain: drives clr/load/enables, counts periods off the chain's RCO.
// State is registered; enp/ld_n/done react to ctr_rco in the same cycle so periodic reloads have no dead cycle.
`timescale 1ns/1ps
module timer_ctrl_161 #(
  parameter  int STAGES  = 2,
  parameter  int TALLY_W = 8,
  localparam int W       = 4 * STAGES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               periodic,
  input  logic [W-1:0]       preset,
  input  logic               ctr_rco,
  output logic               ctr_clr_n,
  output logic               ctr_ld_n,
  output logic               ctr_enp,
  output logic               ctr_ent,
  output logic [W-1:0]       ctr_d,
  output logic               busy,
  output logic               done,
  output logic [TALLY_W-1:0] tally
);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_LOAD, S_RUN, S_PAUSE} state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         preset_q, preset_d;
  logic                 periodic_q, periodic_d;
  logic [TALLY_W-1:0]   tally_q, tally_d, tally_inc;

  assign tally_inc = (&tally_q) ? tally_q : tally_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    preset_d   = preset_q;
    periodic_d = periodic_q;
    tally_d    = tally_q;
    ctr_clr_n  = 1'b1;
    ctr_ld_n   = 1'b1;
    ctr_enp    = 1'b0;
    ctr_ent    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_CLEAR: begin
        ctr_clr_n = 1'b0;
        state_d   = S_IDLE;
      end
      S_IDLE: begin
        if (stop) begin
          state_d = S_CLEAR;
        end else if (start) begin
          preset_d   = preset;
          periodic_d = periodic;
          tally_d    = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        busy     = 1'b1;
        ctr_ld_n = 1'b0;
        if (stop)       state_d = S_CLEAR;
        else if (pause) state_d = S_PAUSE;
        else            state_d = S_RUN;
      end
      S_RUN: begin
        busy    = 1'b1;
        ctr_ent = 1'b1;
        // Priority: stop, then pause (counter holds, terminal count is re-seen later), then terminal count.
        if (stop) begin
          state_d = S_CLEAR;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else if (ctr_rco) begin
          done    = 1'b1;
          tally_d = tally_inc;
          if (periodic_q) begin
            ctr_ld_n = 1'b0;
            ctr_enp  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          ctr_enp = 1'b1;
        end
      end
      S_PAUSE: begin
        busy    = 1'b1;
        ctr_ent = 1'b1;
        if (stop)        state_d = S_CLEAR;
        else if (!pause) state_d = S_RUN;
      end
      default: state_d = S_CLEAR;
    endcase

    if (rst) begin
      ctr_clr_n = 1'b0;
      ctr_ld_n  = 1'b1;
      ctr_enp   = 1'b0;
      ctr_ent   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
    end
  end

  assign ctr_d = rst ? '0 : preset_q;
  assign tally = tally_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CLEAR;
      preset_q   <= '0;
      periodic_q <= 1'b0;
      tally_q    <= '0;
    end else begin
      state_q    <= state_d;
      preset_q   <= preset_d;
      periodic_q <= periodic_d;
      tally_q    <= tally_d;
    end
  end

endmodule

// File: tb/tb_timer_ctrl_161.sv
// Directed bench for timer_ctrl_161 driving a behavioural 8-bit 74x161 chain.
`timescale 1ns/1ps
module tb_timer_ctrl_161;

  logic       clk = 1'b0;
  logic       rst, start, stop, pause, periodic;
  logic [7:0] preset;
  logic       ctr_rco, ctr_clr_n, ctr_ld_n, ctr_enp, ctr_ent, busy, done;
  logic [7:0] ctr_d, tally, cnt;

  int tests = 0;
  int fails = 0;

  timer_ctrl_161 #(.STAGES(2), .TALLY_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .periodic(periodic), .preset(preset), .ctr_rco(ctr_rco),
    .ctr_clr_n(ctr_clr_n), .ctr_ld_n(ctr_ld_n), .ctr_enp(ctr_enp),
    .ctr_ent(ctr_ent), .ctr_d(ctr_d), .busy(busy), .done(done), .tally(tally)
  );

  always #5 clk = ~clk;

  // Two cascaded 74x161 stages collapse to one 8-bit counter; RCO needs ENT and all-ones.
  always @(posedge clk) begin
    if (!ctr_clr_n)             cnt <= 8'h00;
    else if (!ctr_ld_n)         cnt <= ctr_d;
    else if (ctr_enp && ctr_ent) cnt <= cnt + 8'h01;
  end
  assign ctr_rco = ctr_ent && (cnt == 8'hFF);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int ndone;
    int done_at;
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; periodic = 1'b0; preset = 8'h00;

    // Reset: clr_n low for both reset cycles and the CLEAR cycle after.
    cyc(); #1; chk("rst_clr_n_1", ctr_clr_n, 0);
    cyc(); #1; chk("rst_clr_n_2", ctr_clr_n, 0);
    chk("rst_done", done, 0);
    rst = 1'b0; #1;
    chk("clear_clr_n", ctr_clr_n, 0);
    chk("clear_busy", busy, 0);
    cyc(); #1;
    chk("idle_clr_n", ctr_clr_n, 1);
    chk("idle_busy", busy, 0);
    chk("idle_en", {ctr_enp, ctr_ent}, 0);
    chk("idle_ld_n", ctr_ld_n, 1);
    chk("idle_tally", tally, 0);
    chk("idle_cnt", cnt, 8'h00);

    // One-shot, preset FA: 6 RUN cycles, done on the last with count FF.
    periodic = 1'b0; preset = 8'hFA; start = 1'b1;
    cyc(); start = 1'b0; #1;
    chk("os_load_ld_n", ctr_ld_n, 0);
    chk("os_load_d", ctr_d, 8'hFA);
    chk("os_load_enp", ctr_enp, 0);
    chk("os_load_busy", busy, 1);
    for (int i = 1; i <= 6; i++) begin
      cyc(); #1;
      chk("os_cnt", cnt, 8'hF9 + i[7:0]);
      chk("os_done", done, (i == 6));
    end
    cyc(); #1;
    chk("os_after_cnt", cnt, 8'hFF);
    chk("os_after_busy", busy, 0);
    chk("os_after_tally", tally, 1);
    chk("os_after_done", done, 0);
    cyc(); #1;
    chk("os_hold_cnt", cnt, 8'hFF);

    // Periodic, preset FD: FD,FE,FF,FD... with done on every FF.
    periodic = 1'b1; preset = 8'hFD; start = 1'b1;
    cyc(); start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] exp_c;
      cyc(); #1;
      exp_c = 8'hFD + 8'(i % 3);
      chk("per_cnt", cnt, exp_c);
      chk("per_done", done, (i % 3 == 2));
      if (done) ndone++;
    end
    chk("per_ndone", ndone, 4);
    cyc(); #1;
    chk("per_tally", tally, 4);
    chk("per_wrap_cnt", cnt, 8'hFD);

    // Stop in the same cycle as RCO: no done, tally holds, counter cleared.
    cyc(); cyc();
    stop = 1'b1; #1;
    chk("stop_rco_cnt", cnt, 8'hFF);
    chk("stop_rco_done", done, 0);
    chk("stop_rco_enp", ctr_enp, 0);
    cyc(); stop = 1'b0; #1;
    chk("stop_clr_n", ctr_clr_n, 0);
    chk("stop_tally", tally, 4);
    cyc(); #1;
    chk("stop_idle_clr_n", ctr_clr_n, 1);
    chk("stop_idle_cnt", cnt, 8'h00);
    chk("stop_idle_busy", busy, 0);

    // Pause high for 4 cycles from RUN cycle 5: frozen for those plus the PAUSE exit cycle,
    // so done moves from RUN cycle 16 to 21.
    periodic = 1'b1; preset = 8'hF0; start = 1'b1;
    cyc(); start = 1'b0;
    done_at = 0;
    for (int n = 1; n <= 24; n++) begin
      cyc();
      pause = (n >= 5 && n <= 8);
      #1;
      if (n >= 5 && n <= 10) chk("pause_freeze", cnt, 8'hF4);
      if (n == 7) chk("pause_busy", busy, 1);
      if (done && done_at == 0) done_at = n;
    end
    chk("pause_done_at", done_at, 21);
    stop = 1'b1; cyc(); stop = 1'b0; cyc();

    // start+stop together in IDLE: straight to CLEAR, no load.
    start = 1'b1; stop = 1'b1; #1;
    chk("ss_ld_n", ctr_ld_n, 1);
    cyc(); start = 1'b0; stop = 1'b0; #1;
    chk("ss_clr_n", ctr_clr_n, 0);
    chk("ss_busy", busy, 0);
    chk("ss_ld_n2", ctr_ld_n, 1);
    cyc(); #1;
    chk("ss_idle_clr_n", ctr_clr_n, 1);
    chk("ss_idle_busy", busy, 0);

    // start during RUN is ignored: reload still uses FC and tally is not reset.
    periodic = 1'b1; preset = 8'hFC; start = 1'b1;
    cyc(); start = 1'b0;
    cyc(); preset = 8'h10; start = 1'b1; #1;
    chk("ign_cnt", cnt, 8'hFC);
    cyc(); start = 1'b0; periodic = 1'b0;
    cyc(); cyc(); #1;
    chk("ign_done", done, 1);
    cyc(); #1;
    chk("ign_reload", cnt, 8'hFC);
    chk("ign_tally", tally, 1);
    chk("ign_busy", busy, 1);
    stop = 1'b1; cyc(); stop = 1'b0; cyc();

    // Preset FF periodic: done every RUN cycle, tally saturates at FF.
    periodic = 1'b1; preset = 8'hFF; start = 1'b1;
    cyc(); start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 260; i++) begin
      cyc(); #1;
      if (done) ndone++;
    end
    chk("sat_ndone", ndone, 260);
    chk("sat_tally", tally, 8'hFF);

    // Synchronous reset mid-run: done suppressed despite RCO, tally cleared, counter cleared.
    rst = 1'b1; #1;
    chk("mrst_rco", ctr_rco, 0);
    chk("mrst_done", done, 0);
    chk("mrst_clr_n", ctr_clr_n, 0);
    cyc(); rst = 1'b0; #1;
    chk("mrst_tally", tally, 0);
    chk("mrst_clear", ctr_clr_n, 0);
    cyc(); #1;
    chk("mrst_cnt", cnt, 8'h00);
    chk("mrst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
